key_event_sequencer: RTL and testbench

KEY_EVENT_SEQUENCER -- requirements
Module: key_event_sequencer

---
 rtl/key_event_sequencer.sv | 222 ++++++++++++++++++++++
 tb/tb_key_event_sequencer.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_event_sequencer.sv
// key_event_sequencer
//
// Turns a raw keyboard scan-code byte stream into key events. E0 marks an
// extended code, F0 marks a release (break), E1 sequences are not supported
// and are reported as protocol errors. Make events are reported on
// key_data/key_ext with a one-cycle key_event pulse. key_pressed is held
// high for at least HOLD_CYCLES after a make so that a short tap is still
// visible to the LED controller. A prefix left dangling for TIMEOUT_CYCLES
// idle cycles is abandoned with a seq_err pulse.
//
// Build option KEY_REPEAT_FILTER_EN: when defined, a typematic repeat of the
// key already held (same code and ext while key_pressed=1) does not pulse
// key_event; it only re-arms the hold timer. When undefined, every make
// event pulses key_event.
//
// state   | meaning
// --------+---------------------------------------------------
// IDLE    | no prefix pending, next byte starts a sequence
// EXT     | E0 seen, waiting for an extended code or F0
// BRK     | F0 seen, waiting for the code being released
// EXT_BRK | E0 F0 seen, waiting for the extended code released

module key_event_sequencer #(
    parameter int HOLD_CYCLES    = 27000,
    parameter int TIMEOUT_CYCLES = 270000
) (
    input  logic       clock27,
    input  logic       reset_n,
    input  logic       scan_valid,
    input  logic [7:0] scan_data,
    output logic [7:0] key_data,
    output logic       key_ext,
    output logic       key_pressed,
    output logic       key_event,
    output logic       seq_err
);

    // The hold timer never holds more than HOLD_CYCLES-1 and the timeout
    // counter never passes TIMEOUT_CYCLES-1, so $clog2 of the parameter is
    // wide enough for both and neither can wrap.
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int TO_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_ZERO = '0;
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

    localparam logic [7:0] BYTE_EXT = 8'hE0;
    localparam logic [7:0] BYTE_BRK = 8'hF0;
    localparam logic [7:0] BYTE_E1  = 8'hE1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_EXT     = 2'd1,
        S_BRK     = 2'd2,
        S_EXT_BRK = 2'd3
    } state_t;

    state_t              r_state;
    logic [7:0]          r_key_data;
    logic                r_key_ext;
    logic                r_key_pressed;
    logic                r_key_event;
    logic                r_seq_err;
    logic                r_clr_pend;
    logic [HOLD_W-1:0]   r_hold_cnt;
    logic [TO_W-1:0]     r_to_cnt;

    logic                w_is_e0;
    logic                w_is_f0;
    logic                w_is_e1;
    logic                w_is_prefix;
    state_t              w_next_state;
    logic                w_make;
    logic                w_break;
    logic                w_ev_ext;
    logic                w_proto_err;
    logic                w_timeout;
    logic                w_same_key;
    logic                w_break_match;
    logic                w_repeat;
    logic                w_hold_zero;

    assign w_is_e0     = (scan_data == BYTE_EXT);
    assign w_is_f0     = (scan_data == BYTE_BRK);
    assign w_is_e1     = (scan_data == BYTE_E1);
    assign w_is_prefix = w_is_e0 | w_is_f0 | w_is_e1;

    assign w_hold_zero = (r_hold_cnt == HOLD_ZERO);

    // Incoming event refers to the key currently latched on key_data/key_ext.
    assign w_same_key    = (scan_data == r_key_data) && (w_ev_ext == r_key_ext);
    assign w_break_match = w_break && w_same_key;

`ifdef KEY_REPEAT_FILTER_EN
    // A repeat is a make of the key that is still reported as held.
    assign w_repeat = w_make && w_same_key && r_key_pressed;
`else
    assign w_repeat = 1'b0;
`endif

    // Byte classification and next-state selection. A byte arriving on the
    // cycle the timeout would expire takes priority, so no error is raised.
    always_comb begin
        w_next_state = r_state;
        w_make       = 1'b0;
        w_break      = 1'b0;
        w_ev_ext     = 1'b0;
        w_proto_err  = 1'b0;
        w_timeout    = 1'b0;
        if (scan_valid) begin
            case (r_state)
                S_IDLE: begin
                    if (w_is_e0) begin
                        w_next_state = S_EXT;
                    end else if (w_is_f0) begin
                        w_next_state = S_BRK;
                    end else if (w_is_e1) begin
                        w_proto_err = 1'b1;
                    end else begin
                        w_make = 1'b1;
                    end
                end
                S_EXT: begin
                    w_next_state = S_IDLE;
                    if (w_is_f0) begin
                        w_next_state = S_EXT_BRK;
                    end else if (w_is_e0 || w_is_e1) begin
                        w_proto_err = 1'b1;
                    end else begin
                        w_make   = 1'b1;
                        w_ev_ext = 1'b1;
                    end
                end
                S_BRK, S_EXT_BRK: begin
                    w_next_state = S_IDLE;
                    if (w_is_prefix) begin
                        w_proto_err = 1'b1;
                    end else begin
                        w_break  = 1'b1;
                        w_ev_ext = (r_state == S_EXT_BRK);
                    end
                end
                default: begin
                    w_next_state = S_IDLE;
                end
            endcase
        end else if ((r_state != S_IDLE) && (r_to_cnt == TO_LAST)) begin
            w_next_state = S_IDLE;
            w_timeout    = 1'b1;
        end
    end

    // Sequencer state and the two single-cycle status pulses.
    always_ff @(posedge clock27 or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_key_event <= 1'b0;
            r_seq_err   <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_key_event <= w_make & ~w_repeat;
            r_seq_err   <= w_proto_err | w_timeout;
        end
    end

    // Idle-cycle counter for the prefix states; held at zero in IDLE and
    // restarted by every accepted byte.
    always_ff @(posedge clock27 or negedge reset_n) begin
        if (!reset_n) begin
            r_to_cnt <= '0;
        end else if ((r_state == S_IDLE) || scan_valid || w_timeout) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    // Key latch, hold timer and deferred release. A release that arrives
    // before the hold time is up is remembered and applied when the timer
    // has run out; a new make in the meantime cancels it.
    always_ff @(posedge clock27 or negedge reset_n) begin
        if (!reset_n) begin
            r_key_data    <= 8'h00;
            r_key_ext     <= 1'b0;
            r_key_pressed <= 1'b0;
            r_clr_pend    <= 1'b0;
            r_hold_cnt    <= '0;
        end else begin
            if (!w_hold_zero) begin
                r_hold_cnt <= r_hold_cnt - 1'b1;
            end

            if (r_clr_pend && w_hold_zero) begin
                r_key_pressed <= 1'b0;
                r_clr_pend    <= 1'b0;
            end

            if (w_make) begin
                r_key_data    <= scan_data;
                r_key_ext     <= w_ev_ext;
                r_key_pressed <= 1'b1;
                r_clr_pend    <= 1'b0;
                r_hold_cnt    <= HOLD_LOAD;
            end else if (w_break_match) begin
                if (w_hold_zero) begin
                    r_key_pressed <= 1'b0;
                    r_clr_pend    <= 1'b0;
                end else begin
                    r_clr_pend    <= 1'b1;
                end
            end
        end
    end

    assign key_data    = r_key_data;
    assign key_ext     = r_key_ext;
    assign key_pressed = r_key_pressed;
    assign key_event   = r_key_event;
    assign seq_err     = r_seq_err;

endmodule

// File: tb/tb_key_event_sequencer.sv
// Bench for key_event_sequencer: directed sequences plus random byte streams.
// The reference model decodes the byte stream as "[E0] [F0] code" sequences
// and predicts, per accepting clock edge, which key events, errors and
// key_pressed transitions the DUT must show. A monitor compares them.

module tb_key_event_sequencer;

    localparam int H = 100;
    localparam int T = 200;

    logic       clk;
    logic       reset_n;
    logic       scan_valid;
    logic [7:0] scan_data;
    logic [7:0] key_data;
    logic       key_ext;
    logic       key_pressed;
    logic       key_event;
    logic       seq_err;

    key_event_sequencer #(.HOLD_CYCLES(H), .TIMEOUT_CYCLES(T)) dut (
        .clock27    (clk),
        .reset_n    (reset_n),
        .scan_valid (scan_valid),
        .scan_data  (scan_data),
        .key_data   (key_data),
        .key_ext    (key_ext),
        .key_pressed(key_pressed),
        .key_event  (key_event),
        .seq_err    (seq_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int t; logic [7:0] code; logic ext; } ev_t;
    typedef struct { int t; logic lvl; } pr_t;

    ev_t ev_q[$];
    int  err_q[$];
    pr_t pr_q[$];

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input bit ok, input string name, input string msg);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: %s", name, msg);
    endtask

    // ---------------- reference model ----------------
    logic [7:0] m_pfx[$];
    bit         m_pressed   = 0;
    logic [7:0] m_kd        = 8'h00;
    bit         m_ke        = 0;
    int         m_make_at   = 0;
    bit         m_fall_pend = 0;
    int         m_fall_at   = 0;
    bit         m_to_pend   = 0;
    int         m_to_at     = 0;

    task automatic model_make(input logic [7:0] code, input bit ext, input int c);
        bit rep;
        if (m_fall_pend) begin
            void'(pr_q.pop_back());
            m_fall_pend = 0;
        end
`ifdef KEY_REPEAT_FILTER_EN
        rep = m_pressed && (code == m_kd) && (ext == m_ke);
`else
        rep = 0;
`endif
        if (!rep) ev_q.push_back('{t: c, code: code, ext: ext});
        if (!m_pressed) pr_q.push_back('{t: c, lvl: 1'b1});
        m_pressed = 1;
        m_kd      = code;
        m_ke      = ext;
        m_make_at = c;
    endtask

    task automatic model_break(input logic [7:0] code, input bit ext, input int c);
        if (m_pressed && !m_fall_pend && code == m_kd && ext == m_ke) begin
            m_fall_at   = (c > m_make_at + H) ? c : m_make_at + H;
            m_fall_pend = 1;
            pr_q.push_back('{t: m_fall_at, lvl: 1'b0});
        end
    endtask

    // Byte b is accepted at clock edge number c.
    task automatic model_byte(input logic [7:0] b, input int c);
        bit has_e0, has_f0;
        if (m_to_pend) begin
            if (c <= m_to_at) void'(err_q.pop_back());
            else m_pfx.delete();
            m_to_pend = 0;
        end
        if (m_fall_pend && c > m_fall_at) begin
            m_pressed   = 0;
            m_fall_pend = 0;
        end
        has_e0 = 0;
        has_f0 = 0;
        foreach (m_pfx[i]) begin
            if (m_pfx[i] == 8'hE0) has_e0 = 1;
            if (m_pfx[i] == 8'hF0) has_f0 = 1;
        end
        if (b == 8'hE1) begin
            err_q.push_back(c);
            m_pfx.delete();
        end else if (b == 8'hE0) begin
            if (m_pfx.size() == 0) m_pfx.push_back(b);
            else begin err_q.push_back(c); m_pfx.delete(); end
        end else if (b == 8'hF0) begin
            if (has_f0) begin err_q.push_back(c); m_pfx.delete(); end
            else m_pfx.push_back(b);
        end else begin
            m_pfx.delete();
            if (has_f0) model_break(b, has_e0, c);
            else model_make(b, has_e0, c);
        end
        if (m_pfx.size() != 0) begin
            m_to_pend = 1;
            m_to_at   = c + T;
            err_q.push_back(m_to_at);
        end
    endtask

    task automatic model_reset();
        if (m_to_pend && m_to_at > cyc) void'(err_q.pop_back());
        if (m_fall_pend && m_fall_at > cyc) void'(pr_q.pop_back());
        m_pfx.delete();
        m_pressed   = 0;
        m_kd        = 8'h00;
        m_ke        = 0;
        m_fall_pend = 0;
        m_to_pend   = 0;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        scan_valid = 1'b1;
        scan_data  = b;
        model_byte(b, cyc + 1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            scan_valid = 1'b0;
            scan_data  = $urandom_range(0, 255);
        end
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        reset_n    = 1'b0;
        scan_valid = 1'b0;
        model_reset();
        repeat (n) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // ---------------- monitor ----------------
    initial begin
        bit  prev_p;
        ev_t e;
        pr_t p;
        int  et;
        prev_p = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!reset_n) begin
                prev_p = 0;
                continue;
            end
            while (ev_q.size() > 0 && ev_q[0].t < cyc) begin
                e = ev_q.pop_front();
                chk(0, "key_event missing", $sformatf("no pulse, required code %02h ext %0d at cycle %0d", e.code, e.ext, e.t));
            end
            while (err_q.size() > 0 && err_q[0] < cyc) begin
                et = err_q.pop_front();
                chk(0, "seq_err missing", $sformatf("no pulse, required at cycle %0d", et));
            end
            while (pr_q.size() > 0 && pr_q[0].t < cyc) begin
                p = pr_q.pop_front();
                chk(0, "key_pressed missing", $sformatf("no change, required level %0d at cycle %0d", p.lvl, p.t));
            end
            if (key_event) begin
                if (ev_q.size() == 0) begin
                    chk(0, "key_event unexpected", $sformatf("pulse code %02h ext %0d at cycle %0d, none expected", key_data, key_ext, cyc));
                end else begin
                    e = ev_q.pop_front();
                    chk(e.t == cyc && key_data == e.code && key_ext == e.ext, "key_event",
                        $sformatf("got code %02h ext %0d at cycle %0d, required code %02h ext %0d at cycle %0d",
                                  key_data, key_ext, cyc, e.code, e.ext, e.t));
                end
            end
            if (seq_err) begin
                if (err_q.size() == 0) begin
                    chk(0, "seq_err unexpected", $sformatf("pulse at cycle %0d, none expected", cyc));
                end else begin
                    et = err_q.pop_front();
                    chk(et == cyc, "seq_err", $sformatf("got pulse at cycle %0d, required at cycle %0d", cyc, et));
                end
            end
            if (key_pressed !== prev_p) begin
                if (pr_q.size() == 0) begin
                    chk(0, "key_pressed unexpected", $sformatf("changed to %0d at cycle %0d, no change expected", key_pressed, cyc));
                end else begin
                    p = pr_q.pop_front();
                    chk(p.t == cyc && key_pressed == p.lvl, "key_pressed",
                        $sformatf("got level %0d at cycle %0d, required level %0d at cycle %0d", key_pressed, cyc, p.lvl, p.t));
                end
            end
            prev_p = key_pressed;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] pool[12];
        int r, gap;
        pool = '{8'hE0, 8'hF0, 8'hE1, 8'h1C, 8'h75, 8'h22, 8'h1C, 8'h75, 8'h5A, 8'h1C, 8'hF0, 8'hE0};

        reset_n    = 1'b0;
        scan_valid = 1'b0;
        scan_data  = 8'h00;
        repeat (3) @(negedge clk);
        chk(key_data == 8'h00, "reset key_data", $sformatf("got %02h, required 00", key_data));
        chk(key_ext == 1'b0, "reset key_ext", $sformatf("got %0d, required 0", key_ext));
        chk(key_pressed == 1'b0, "reset key_pressed", $sformatf("got %0d, required 0", key_pressed));
        chk(key_event == 1'b0, "reset key_event", $sformatf("got %0d, required 0", key_event));
        chk(seq_err == 1'b0, "reset seq_err", $sformatf("got %0d, required 0", seq_err));
        reset_n = 1'b1;
        idle(4);

        // make, release long after the hold time
        send(8'h1C); idle(120); send(8'hF0); send(8'h1C); idle(10);
        // extended make and extended release
        send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75); idle(120);
        // release inside the hold time is deferred
        send(8'h1C); idle(9); send(8'hF0); send(8'h1C); idle(110);
        // prefix timeout, then a plain make
        send(8'hE0); idle(T + 5); send(8'h1C); idle(3);
        // byte arriving exactly at the expiry cycle is decoded, no error
        send(8'hE0); idle(T - 1); send(8'h22); idle(3);
        // expiry one cycle earlier than the next byte
        send(8'hF0); idle(T); send(8'h1C); idle(3);
        // typematic repeats
        send(8'h1C); send(8'h1C); send(8'h1C); idle(5);
        // protocol errors and a non-matching release
        send(8'hE1); send(8'hE0); send(8'hE0); send(8'hF0); send(8'hF0);
        send(8'hE0); send(8'hE1); send(8'hF0); send(8'hE1);
        send(8'hF0); send(8'h22); idle(5);
        send(8'hF0); send(8'h1C); send(8'h75); send(8'hF0); send(8'h75); idle(120);
        // reset mid-sequence discards the prefixes
        send(8'hE0); send(8'hF0); do_reset(3); idle(2);
        send(8'h1C); idle(5);

        for (int i = 0; i < 300; i++) begin
            send(pool[$urandom_range(0, 11)]);
            r = $urandom_range(0, 99);
            if (r < 40)      gap = 0;
            else if (r < 85) gap = $urandom_range(1, 20);
            else if (r < 95) gap = $urandom_range(H - 10, H + 10);
            else             gap = $urandom_range(T - 3, T + 3);
            if (gap > 0) idle(gap);
        end
        idle(T + H + 20);

        if (m_fall_pend && cyc >= m_fall_at) begin
            m_pressed   = 0;
            m_fall_pend = 0;
        end
        chk(ev_q.size() == 0, "event queue drained", $sformatf("%0d key_event pulses outstanding", ev_q.size()));
        chk(err_q.size() == 0, "error queue drained", $sformatf("%0d seq_err pulses outstanding", err_q.size()));
        chk(pr_q.size() == 0, "pressed queue drained", $sformatf("%0d key_pressed changes outstanding", pr_q.size()));
        chk(key_data == m_kd, "final key_data", $sformatf("got %02h, required %02h", key_data, m_kd));
        chk(key_ext == m_ke, "final key_ext", $sformatf("got %0d, required %0d", key_ext, m_ke));
        chk(key_pressed == m_pressed, "final key_pressed", $sformatf("got %0d, required %0d", key_pressed, m_pressed));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
